riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
- Load/store unit: the core-side initiator for the word-wide, single-write-enable RAM port served by the RAM controller.
- Accepts byte/halfword/word loads and stores from the core pipeline and drives the RAM port address, write data and write enable.
- Sub-word stores are done as read-modify-write; load data is extracted and sign- or zero-extended.
- Sits between the execute stage and the RAM controller.

Parameters:
- RAM_READ_LATENCY, 1: cycles from address presented to ram_data_out valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned or illegal size; valid with resp_valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- ram_adress  out  32  word address to RAM, req_addr with [1:0] forced to 0.
- ram_data_in  out  32  write data to RAM.
- ram_enable_write  out  1  write strobe, one cycle per store.
- ram_data_out  in  32  read data from RAM.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_adress=0, ram_data_in=0, ram_enable_write=0.
- Request capture: a handshake occurs when req_valid && req_ready. All req_* fields are registered on that edge; they are not sampled afterwards.
- States: IDLE, READ, WRITE, RESP.
  - IDLE: on handshake:
    - error -> RESP;
    - load, or store with size != 2 -> READ, with latency counter = RAM_READ_LATENCY;
    - word store -> WRITE.
  - READ: ram_adress held. The counter decrements each cycle. When it reaches 0, ram_data_out is captured:
    - load -> RESP;
    - sub-word store -> WRITE.
  - WRITE: ram_enable_write=1 for exactly one cycle, with ram_data_in = merged word (sub-word) or req_wdata (word). Next state RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready returns to 1 in the cycle after RESP.
- Error conditions:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size=3.
- Error handling: no RAM access and ram_enable_write stays 0. Response appears 2 cycles after the handshake, with resp_err=1 and resp_rdata=0.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Little-endian: byte k = data[8k+7:8k].
  - Sign-extend unless req_unsigned. req_unsigned is ignored for words.
- Store merge: the lane from req_wdata[7:0] or [15:0] replaces the matching bits of the read word; other bytes are preserved.
- Latency from handshake to resp_valid:
  - load: RAM_READ_LATENCY+2;
  - word store: 2;
  - sub-word store: RAM_READ_LATENCY+3;
  - error: 2.
- Back-to-back requests: one outstanding request only. A new request can be accepted 1 cycle after resp_valid.
- ram_adress behaviour: holds its last value when idle; ram_enable_write=0 outside WRITE.
- Reset mid-operation: returns to IDLE in the next cycle and aborts any pending write. No partial write is issued if reset arrives in READ. A write issued in the same cycle reset is asserted is suppressed, because the outputs are registered.

Optional Feature:
- Macro: LSU_STATS_EN.
- With the macro defined: adds outputs stat_loads[31:0], stat_stores[31:0] and stat_errs[31:0].
  - Each counts completed responses of its kind on resp_valid.
  - Counters wrap at 2^32 and clear on reset.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package riscv_mem_pkg:
  - size encodings SIZE_B=0, SIZE_H=1, SIZE_W=2;
  - LSU state encoding;
  - function misaligned(size, addr).
- One sub-module: lsu_lane_align, combinational. It performs both load extract/extend and store merge, taking (size, addr[1:0], unsigned, word, wdata) and returning (rdata, merged).

Test Plan:
- Word store then load: store 0xDEADBEEF @0x100 → one ram_enable_write pulse, ram_adress=0x100, resp at +2. Load word @0x100 → resp_rdata=0xDEADBEEF at +3.
- Byte store: RAM[0x100]=0xDEADBEEF, store byte 0x5A @0x102 → READ then write of 0xDE5ABEEF, resp at +4.
- Sign/zero extension: RAM[0x200]=0x0000F080. LB @0x200 → 0xFFFFFF80; LBU @0x200 → 0x00000080; LH @0x200 → 0xFFFFF080; LHU @0x202 → 0x00000000.
- Misalignment: LW @0x101 → resp_err=1, resp_rdata=0, no ram_enable_write. SH @0x103 → error. size=3 → error.
- Reset mid-operation: assert reset during READ of a sub-word store → no ram_enable_write ever pulses, req_ready=1 the cycle after reset.
- Latency sweep: RAM_READ_LATENCY=3 → LW resp at +5. LSU_STATS_EN build: 2 loads, 1 store, 1 error → counters 2/1/1.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: size encodings, LSU state encoding and alignment check shared by the load/store unit
package riscv_mem_pkg;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} lsu_state_e;

    // size 3 is folded in so one call flags every request that must not reach RAM
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        return (size == SIZE_H) ? addr[0] : (size == SIZE_W) ? |addr : (size != SIZE_B);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian load extract/extend and sub-word store merge on one RAM word
module lsu_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] mask;
    always_comb begin
        shift   = (size == SIZE_H) ? {addr[1], 4'b0000} : {addr, 3'b000};
        shifted = word >> shift;
        mask    = (size == SIZE_H) ? 32'h0000_FFFF : (size == SIZE_B) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        rdata   = (size == SIZE_H) ? {{16{~is_unsigned & shifted[15]}}, shifted[15:0]} :
                  (size == SIZE_B) ? {{24{~is_unsigned & shifted[7]}}, shifted[7:0]} : shifted;
        merged  = (word & ~(mask << shift)) | ((wdata & mask) << shift);
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit driving a word-wide RAM port; `define LSU_STATS_EN adds load/store/error counters
module riscv_lsu
    import riscv_mem_pkg::*;
#(
    parameter int RAM_READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] ram_adress,
    output logic [31:0] ram_data_in,
    output logic        ram_enable_write,
    input  logic [31:0] ram_data_out
`ifdef LSU_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errs
`endif
);
    lsu_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]  size_q, size_d, addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d, ram_adress_q, ram_adress_d, ram_data_in_q, ram_data_in_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] rdata, merged;

    lsu_lane_align u_align (
        .size        (size_q),
        .addr        (addr_q),
        .is_unsigned (uns_q),
        .word        (ram_data_out),
        .wdata       (wdata_q),
        .rdata       (rdata),
        .merged      (merged)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        size_d        = size_q;
        uns_d         = uns_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        resp_rdata_d  = '0;
        ram_adress_d  = ram_adress_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid && req_ready_q) begin
                write_d     = req_write;
                size_d      = req_size;
                uns_d       = req_unsigned;
                addr_d      = req_addr[1:0];
                wdata_d     = req_wdata;
                err_d       = misaligned(req_size, req_addr[1:0]);
                req_ready_d = 1'b0;
                cnt_d       = 3'(RAM_READ_LATENCY);
                if (err_d) begin
                    state_d = ST_RESP;
                end else begin
                    ram_adress_d  = {req_addr[31:2], 2'b00};
                    ram_we_d      = req_write && req_size == SIZE_W;
                    ram_data_in_d = ram_we_d ? req_wdata : ram_data_in_q;
                    state_d       = ram_we_d ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end else begin
                state_d       = write_q ? ST_WRITE : ST_RESP;
                ram_we_d      = write_q;
                ram_data_in_d = write_q ? merged : ram_data_in_q;
                resp_valid_d  = !write_q;
                resp_rdata_d  = write_q ? '0 : rdata;
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            // non-error paths enter with the pulse already raised; errors spend one quiet cycle here first
            ST_RESP: begin
                state_d      = resp_valid_q ? ST_IDLE : ST_RESP;
                req_ready_d  = resp_valid_q;
                resp_valid_d = !resp_valid_q;
                resp_err_d   = !resp_valid_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LSU_STATS_EN
    logic [31:0] stat_loads_q, stat_stores_q, stat_errs_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_errs_q   <= '0;
        end else if (resp_valid_q) begin
            stat_errs_q   <= stat_errs_q + 32'(err_q);
            stat_stores_q <= stat_stores_q + 32'(!err_q && write_q);
            stat_loads_q  <= stat_loads_q + 32'(!err_q && !write_q);
        end
    end
    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            size_q        <= SIZE_B;
            uns_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            ram_adress_q  <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
            ram_adress_q  <= ram_adress_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_err         = resp_err_q;
    assign resp_rdata       = resp_rdata_q;
    assign ram_adress       = ram_adress_q;
    assign ram_data_in      = ram_data_in_q;
    assign ram_enable_write = ram_we_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed bench for riscv_lsu against a word-array memory model; checks counters when LSU_STATS_EN is defined
module tb_riscv_lsu;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, ram_enable_write;
    logic [31:0] resp_rdata, ram_adress, ram_data_in, ram_data_out;

    logic        req_valid_3 = 1'b0;
    logic        req_ready_3, resp_valid_3, resp_err_3, ram_enable_write_3;
    logic [31:0] resp_rdata_3, ram_adress_3, ram_data_in_3, ram_data_out_3;

`ifdef LSU_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_errs;
    logic [31:0] stat_loads_3, stat_stores_3, stat_errs_3;
`endif

    riscv_lsu #(.RAM_READ_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .ram_adress(ram_adress),
        .ram_data_in(ram_data_in), .ram_enable_write(ram_enable_write),
        .ram_data_out(ram_data_out)
`ifdef LSU_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
    );

    riscv_lsu #(.RAM_READ_LATENCY(LAT3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid_3), .req_ready(req_ready_3),
        .req_write(1'b0), .req_size(2'd2), .req_unsigned(1'b0),
        .req_addr(32'h100), .req_wdata(32'h0), .resp_valid(resp_valid_3),
        .resp_err(resp_err_3), .resp_rdata(resp_rdata_3), .ram_adress(ram_adress_3),
        .ram_data_in(ram_data_in_3), .ram_enable_write(ram_enable_write_3),
        .ram_data_out(ram_data_out_3)
`ifdef LSU_STATS_EN
        , .stat_loads(stat_loads_3), .stat_stores(stat_stores_3), .stat_errs(stat_errs_3)
`endif
    );

    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
    logic [31:0] pipe [0:3] = '{default: 32'h0};
    logic [31:0] pipe3 [0:3] = '{default: 32'h0};
    assign ram_data_out   = pipe[LAT-1];
    assign ram_data_out_3 = pipe3[LAT3-1];

    always @(posedge clk) begin
        if (ram_enable_write) mem[ram_adress[11:2]] <= ram_data_in;
        pipe[0]  <= mem[ram_adress[11:2]];
        pipe3[0] <= mem[ram_adress_3[11:2]];
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        for (int j = 1; j < 4; j++) pipe3[j] <= pipe3[j-1];
    end

    int checks = 0, errors = 0;
    int n_loads = 0, n_stores = 0, n_errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_err(input logic [1:0] s, input logic [31:0] a);
        return s == 2'd3 || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (s == 2'd2) return w;
        if (s == 2'd1) begin
            v = (a % 4 >= 2) ? w / 65536 : w % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = (w >> (8 * (a % 4))) % 256;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_word(input logic [1:0] s, input logic [31:0] a, input logic [31:0] w, input logic [31:0] wd);
        logic [7:0] b [4];
        int lane;
        if (s == 2'd2) return wd;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        lane = int'(a % 4);
        if (s == 2'd0) b[lane] = wd[7:0];
        else begin
            b[lane]     = wd[7:0];
            b[lane + 1] = wd[15:8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // issues one request at a negedge and checks every cycle up to one past the response
    task automatic do_req(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got_r, output logic [31:0] got_w);
        logic        e;
        int          lat, wc;
        logic [31:0] old, exp_r, exp_w;
        e     = is_err(s, a);
        old   = ref_mem[a[11:2]];
        exp_r = (e || w) ? 32'h0 : load_val(s, u, a, old);
        exp_w = store_word(s, a, old, wd);
        lat   = e ? 2 : !w ? LAT + 2 : (s == 2'd2) ? 2 : LAT + 3;
        wc    = (e || !w) ? 0 : (s == 2'd2) ? 1 : LAT + 2;
        got_r = '0;
        got_w = '0;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_size = ~s; req_unsigned = ~u; req_addr = 32'h0BAD_0BAD; req_wdata = 32'h1357_9BDF;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("resp_valid", resp_valid, k == lat);
            chk("ram_we", ram_enable_write, k == wc);
            chk("req_ready_busy", req_ready, 0);
            if (k == 1 && !e) chk("ram_adress", ram_adress, {a[31:2], 2'b00});
            if (k == wc) begin
                chk("ram_data_in", ram_data_in, exp_w);
                got_w = ram_data_in;
            end
            if (k == lat) begin
                chk("resp_err", resp_err, e);
                chk("resp_rdata", resp_rdata, exp_r);
                got_r = resp_rdata;
            end
        end
        @(negedge clk);
        chk("req_ready_after", req_ready, 1);
        chk("resp_valid_after", resp_valid, 0);
        chk("ram_we_after", ram_enable_write, 0);
        if (e) n_errs++;
        else if (w) begin
            n_stores++;
            ref_mem[a[11:2]] = exp_w;
        end else n_loads++;
    endtask

    logic [31:0] r, wv;
    int k3;
    logic we3_seen;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_ram_adress", ram_adress, 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_ram_we", ram_enable_write, 0);
        reset = 1'b0;
        @(negedge clk);

        do_req(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, r, wv); chk("lit_sw", wv, 32'hDEAD_BEEF);
        do_req(0, 2'd2, 0, 32'h100, 32'h0, r, wv);         chk("lit_lw", r, 32'hDEAD_BEEF);
        do_req(1, 2'd0, 0, 32'h102, 32'h0000_005A, r, wv); chk("lit_sb", wv, 32'hDE5A_BEEF);
        do_req(0, 2'd2, 0, 32'h100, 32'h0, r, wv);         chk("lit_lw2", r, 32'hDE5A_BEEF);
        do_req(1, 2'd2, 0, 32'h200, 32'h0000_F080, r, wv);
        do_req(0, 2'd0, 0, 32'h200, 32'h0, r, wv);         chk("lit_lb", r, 32'hFFFF_FF80);
        do_req(0, 2'd0, 1, 32'h200, 32'h0, r, wv);         chk("lit_lbu", r, 32'h0000_0080);
        do_req(0, 2'd1, 0, 32'h200, 32'h0, r, wv);         chk("lit_lh", r, 32'hFFFF_F080);
        do_req(0, 2'd1, 1, 32'h202, 32'h0, r, wv);         chk("lit_lhu", r, 32'h0000_0000);
        do_req(0, 2'd2, 0, 32'h101, 32'h0, r, wv);
        do_req(1, 2'd1, 0, 32'h103, 32'h1234, r, wv);
        do_req(0, 2'd3, 0, 32'h200, 32'h0, r, wv);
        do_req(1, 2'd2, 0, 32'h102, 32'hFFFF_FFFF, r, wv);
        do_req(1, 2'd1, 0, 32'h202, 32'h1234_A5A5, r, wv); chk("lit_sh", wv, 32'hA5A5_F080);
        do_req(0, 2'd0, 0, 32'h203, 32'h0, r, wv);         chk("lit_lb3", r, 32'hFFFF_FFA5);
        do_req(0, 2'd1, 1, 32'h202, 32'h0, r, wv);         chk("lit_lhu2", r, 32'h0000_A5A5);
        do_req(0, 2'd0, 0, 32'h201, 32'h0, r, wv);         chk("lit_lb1", r, 32'hFFFF_FFF0);

        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h101; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_we", ram_enable_write, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        reset = 1'b0;
        n_loads = 0; n_stores = 0; n_errs = 0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_we", ram_enable_write, 0);
            chk("post_rst_resp", resp_valid, 0);
        end
        do_req(0, 2'd2, 0, 32'h100, 32'h0, r, wv);         chk("lit_no_partial", r, 32'hDE5A_BEEF);
        do_req(0, 2'd1, 0, 32'h200, 32'h0, r, wv);
        do_req(1, 2'd0, 0, 32'h300, 32'h0000_00C3, r, wv); chk("lit_sb0", wv, 32'h0000_00C3);
        do_req(0, 2'd2, 0, 32'h301, 32'h0, r, wv);

        chk("lat3_ready", req_ready_3, 1);
        req_valid_3 = 1'b1;
        @(posedge clk);
        #1 req_valid_3 = 1'b0;
        k3 = 0;
        we3_seen = 1'b0;
        while (k3 < 20) begin
            @(negedge clk);
            k3++;
            we3_seen = we3_seen | ram_enable_write_3;
            if (resp_valid_3) break;
        end
        chk("lat3_latency", k3, 5);
        chk("lat3_rdata", resp_rdata_3, 32'hDE5A_BEEF);
        chk("lat3_err", resp_err_3, 0);
        chk("lat3_no_write", we3_seen, 0);

`ifdef LSU_STATS_EN
        chk("stat_loads", stat_loads, n_loads);
        chk("stat_stores", stat_stores, n_stores);
        chk("stat_errs", stat_errs, n_errs);
        chk("lit_stat_loads", stat_loads, 2);
        chk("lit_stat_stores", stat_stores, 1);
        chk("lit_stat_errs", stat_errs, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
